// File: rtl/mc_main_control_pkg.sv
// Shared definitions for the multicycle main control FSM: state encodings,
// opcodes, aluop and datapath mux select codes.
package mc_main_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEM_ADR = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WB  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_R_EXEC  = 4'd6,
        ST_R_WB    = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ADDI_EX = 4'd10,
        ST_ADDI_WB = 4'd11,
        ST_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b110;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True when the opcode is one the core executes; addi depends on configuration.
    function automatic logic op_supported(input logic [5:0] op, input logic en_addi);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            OP_ADDI:                              ok = en_addi;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle main control FSM.
module mc_next_state
    import mc_main_control_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit BAD_OP_TRAP = 1'b0
) (
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output state_t      next_state
);

    // Next-state selection; access states wait here until the cache reports ready.
    always_comb begin
        next_state = ST_FETCH;
        case (state)
            ST_FETCH: begin
                if (mem_ready) begin
                    next_state = ST_DECODE;
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!op_supported(opcode, ENABLE_ADDI)) begin
                    next_state = BAD_OP_TRAP ? ST_HALT : ST_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: next_state = ST_MEM_ADR;
                        OP_RTYPE:     next_state = ST_R_EXEC;
                        OP_BEQ:       next_state = ST_BRANCH;
                        OP_J:         next_state = ST_JUMP;
                        OP_ADDI:      next_state = ST_ADDI_EX;
                        default:      next_state = ST_FETCH;
                    endcase
                end
            end
            ST_MEM_ADR: begin
                if (opcode == OP_LW) begin
                    next_state = ST_MEM_RD;
                end else begin
                    next_state = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    next_state = ST_MEM_WB;
                end else begin
                    next_state = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    next_state = ST_FETCH;
                end else begin
                    next_state = ST_MEM_WR;
                end
            end
            ST_R_EXEC:  next_state = ST_R_WB;
            ST_ADDI_EX: next_state = ST_ADDI_WB;
            ST_HALT:    next_state = ST_HALT;
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: next_state = ST_FETCH;
            default:    next_state = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register plus per-state datapath strobes,
// with cache request/ready sequencing for instruction and data accesses.
module mc_main_control
    import mc_main_control_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit BAD_OP_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] aluop,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       halted
);

    state_t state_r;
    state_t next_state_s;

    mc_next_state #(
        .ENABLE_ADDI (ENABLE_ADDI),
        .BAD_OP_TRAP (BAD_OP_TRAP)
    ) u_next_state (
        .state      (state_r),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .next_state (next_state_s)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Output decode; everything is forced low while reset is asserted so a pending access is dropped.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        aluop      = ALUOP_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            case (state_r)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH;
                    illegal_op = !op_supported(opcode, ENABLE_ADDI);
                end
                ST_MEM_ADR, ST_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mdr_write = mem_ready;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                ST_R_EXEC: begin
                    alu_src_a = 1'b1;
                    aluop     = ALUOP_RTYPE;
                end
                ST_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    aluop     = ALUOP_SUB;
                    pc_source = PCSRC_ALUOUT;
                    pc_write  = zero;
                end
                ST_JUMP: begin
                    pc_source = PCSRC_JUMP;
                    pc_write  = 1'b1;
                end
                ST_ADDI_WB: begin
                    reg_write = 1'b1;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end else begin
            halted = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed, table-driven bench for mc_main_control: default build runs the vector
// table, a second build (addi disabled, trap enabled) runs a hand-written halt sequence.
module tb_mc_main_control;

    logic       clk;
    logic       rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_write;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, halted;
    logic [2:0] aluop;

    logic       rst2_n, zero2, mem_ready2;
    logic [5:0] opcode2;
    logic       mem_req2, mem_we2, iord2, ir_write2, mdr_write2, pc_write2;
    logic [1:0] pc_source2, alu_src_b2;
    logic       alu_src_a2, reg_dst2, mem_to_reg2, reg_write2, illegal_op2, halted2;
    logic [2:0] aluop2;

    int n_chk = 0;
    int n_fail = 0;

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .mdr_write(mdr_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op), .halted(halted)
    );

    mc_main_control #(.ENABLE_ADDI(1'b0), .BAD_OP_TRAP(1'b1)) dut_trap (
        .clk(clk), .rst_n(rst2_n), .opcode(opcode2), .zero(zero2), .mem_ready(mem_ready2),
        .mem_req(mem_req2), .mem_we(mem_we2), .iord(iord2), .ir_write(ir_write2),
        .mdr_write(mdr_write2), .pc_write(pc_write2), .pc_source(pc_source2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .aluop(aluop2), .reg_dst(reg_dst2),
        .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .illegal_op(illegal_op2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [18:0] out1 = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_source,
                        alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg, reg_write, illegal_op, halted};
    wire [18:0] out2 = {mem_req2, mem_we2, iord2, ir_write2, mdr_write2, pc_write2, pc_source2,
                        alu_src_a2, alu_src_b2, aluop2, reg_dst2, mem_to_reg2, reg_write2, illegal_op2, halted2};

    function automatic logic [18:0] mk(input logic req, input logic we, input logic io,
                                       input logic irw, input logic mdrw, input logic pcw,
                                       input logic [1:0] pcs, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] aop, input logic rd, input logic m2r,
                                       input logic rw, input logic ill, input logic hlt);
        return {req, we, io, irw, mdrw, pcw, pcs, sa, sb, aop, rd, m2r, rw, ill, hlt};
    endfunction

    //                              req we io irw mdr pcw pcs   sa sb    aop     rd m2r rw ill hlt
    localparam logic [18:0] O_ZERO   = 19'd0;
    localparam logic [18:0] O_FWAIT  = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_FRDY   = mk(1, 0, 0, 1, 0, 1, 2'b00, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_DEC    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_ILL    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b000, 0, 0, 0, 1, 0);
    localparam logic [18:0] O_ADR    = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_RDWAIT = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_RDRDY  = mk(1, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_MEMWB  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 0, 0);
    localparam logic [18:0] O_MEMWR  = mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_REXEC  = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b110, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_RWB    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 0, 0);
    localparam logic [18:0] O_BRT    = mk(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b001, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_BRNT   = mk(0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b001, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_JUMP   = mk(0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [18:0] O_ADDIWB = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1, 0, 0);
    localparam logic [18:0] O_HALT   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1);

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    typedef struct {
        logic        rst_n;
        logic [5:0]  opcode;
        logic        zero;
        logic        mem_ready;
        logic [18:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [18:0] e, input string nm);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.zero = z; v.mem_ready = mr; v.exp = e; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [18:0] got, input logic [18:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, want);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b1;
        rst2_n = 1'b0; opcode2 = RT; zero2 = 1'b0; mem_ready2 = 1'b1;

        add(0, LW,  0, 1, O_ZERO,   "reset_c0");
        add(0, LW,  0, 1, O_ZERO,   "reset_c1");
        // lw: three fetch wait cycles, two MEM_RD wait cycles; ready in DECODE/MEM_ADR is ignored
        add(1, LW,  0, 0, O_FWAIT,  "lw_fetch_wait0");
        add(1, LW,  0, 0, O_FWAIT,  "lw_fetch_wait1");
        add(1, LW,  0, 0, O_FWAIT,  "lw_fetch_wait2");
        add(1, LW,  0, 1, O_FRDY,   "lw_fetch_ready");
        add(1, LW,  0, 1, O_DEC,    "lw_decode");
        add(1, LW,  0, 1, O_ADR,    "lw_mem_adr");
        add(1, LW,  0, 0, O_RDWAIT, "lw_rd_wait0");
        add(1, LW,  0, 0, O_RDWAIT, "lw_rd_wait1");
        add(1, LW,  0, 1, O_RDRDY,  "lw_rd_ready");
        add(1, LW,  0, 1, O_MEMWB,  "lw_wb_cycle10");
        add(1, RT,  0, 1, O_FRDY,   "r_fetch");
        add(1, RT,  0, 1, O_DEC,    "r_decode");
        add(1, RT,  0, 1, O_REXEC,  "r_exec");
        add(1, RT,  0, 1, O_RWB,    "r_wb");
        add(1, BEQ, 1, 1, O_FRDY,   "beq_t_fetch");
        add(1, BEQ, 1, 1, O_DEC,    "beq_t_decode");
        add(1, BEQ, 1, 1, O_BRT,    "beq_taken");
        add(1, BEQ, 0, 1, O_FRDY,   "beq_nt_fetch");
        add(1, BEQ, 0, 1, O_DEC,    "beq_nt_decode");
        add(1, BEQ, 0, 1, O_BRNT,   "beq_not_taken");
        add(1, JMP, 0, 1, O_FRDY,   "j_fetch");
        add(1, JMP, 0, 1, O_DEC,    "j_decode");
        add(1, JMP, 0, 1, O_JUMP,   "j_jump");
        add(1, ADDI,0, 1, O_FRDY,   "addi_fetch");
        add(1, ADDI,0, 1, O_DEC,    "addi_decode");
        add(1, ADDI,0, 1, O_ADR,    "addi_exec");
        add(1, ADDI,0, 1, O_ADDIWB, "addi_wb");
        add(1, SW,  0, 1, O_FRDY,   "sw_fetch");
        add(1, SW,  0, 1, O_DEC,    "sw_decode");
        add(1, SW,  0, 1, O_ADR,    "sw_mem_adr");
        add(1, SW,  0, 1, O_MEMWR,  "sw_write_ready");
        add(1, BAD, 0, 1, O_FRDY,   "bad_fetch");
        add(1, BAD, 0, 1, O_ILL,    "bad_decode_pulse");
        add(1, BAD, 0, 0, O_FWAIT,  "bad_back_to_fetch");
        // reset asserted while a store waits on the cache
        add(1, SW,  0, 1, O_FRDY,   "swr_fetch");
        add(1, SW,  0, 1, O_DEC,    "swr_decode");
        add(1, SW,  0, 1, O_ADR,    "swr_mem_adr");
        add(1, SW,  0, 0, O_MEMWR,  "swr_wait0");
        add(1, SW,  0, 0, O_MEMWR,  "swr_wait1");
        add(0, SW,  0, 0, O_ZERO,   "swr_reset");
        add(1, SW,  0, 0, O_FWAIT,  "swr_after_reset");

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; opcode = tbl[i].opcode;
            zero = tbl[i].zero; mem_ready = tbl[i].mem_ready;
            #1;
            chk(tbl[i].name, out1, tbl[i].exp);
        end

        // Trap build: addi is illegal and traps to HALT until reset.
        @(negedge clk); rst2_n = 1'b0; #1; chk("trap_reset0", out2, O_ZERO);
        @(negedge clk); #1; chk("trap_reset1", out2, O_ZERO);
        @(negedge clk); rst2_n = 1'b1; opcode2 = ADDI; mem_ready2 = 1'b1; #1;
        chk("trap_fetch", out2, O_FRDY);
        @(negedge clk); #1; chk("trap_decode_pulse", out2, O_ILL);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1; chk("trap_halted", out2, O_HALT);
        end
        @(negedge clk); rst2_n = 1'b0; #1; chk("trap_reset_again", out2, O_ZERO);
        @(negedge clk); rst2_n = 1'b1; mem_ready2 = 1'b0; #1;
        chk("trap_released", out2, O_FWAIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
